ibex_rf_write_arbiter: RTL and testbench



---
 rtl/ibex_pkg.sv | 20 ++
 rtl/ibex_rf_load_queue.sv | 82 ++++++++
 rtl/ibex_rf_write_arbiter.sv | 136 +++++++++++++
 tb/tb_ibex_rf_write_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the register-file write path
package ibex_pkg;

    localparam int unsigned RfDataWidth        = 32;
    localparam int unsigned RfLoadDepthDefault = 2;

    typedef struct packed {
        logic                   we;
        logic [4:0]             waddr;
        logic [RfDataWidth-1:0] wdata;
    } rf_wr_t;

    // A pending write to x0 never hazards: x0 always reads as zero.
    function automatic logic rf_addr_hit(input logic [4:0] raddr,
                                         input logic [4:0] waddr,
                                         input logic       wvalid);
        return wvalid && (raddr != 5'd0) && (raddr == waddr);
    endfunction

endpackage

// File: rtl/ibex_rf_load_queue.sv
// rtl/ibex_rf_load_queue.sv - in-order FIFO of outstanding load destinations
module ibex_rf_load_queue #(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [4:0]         push_addr_i,
    input  logic               pop_i,
    output logic [4:0]         head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [Depth*5-1:0] entries_o,
    output logic [Depth-1:0]   entry_valid_o
);

    logic [4:0]      mem_q [Depth];
    logic [4:0]      mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [Depth-1:0] vld_q, vld_d;
    logic            push_en, pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign entry_valid_o = vld_q;

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entries_o[i*5 +: 5] = mem_q[i];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        count_d  = count_q;
        if (pop_en) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (push_en) begin
            mem_d[wr_ptr_q] = push_addr_i;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// rtl/ibex_rf_write_arbiter.sv - merges ALU and load writes onto one register file write port
module ibex_rf_write_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = RfDataWidth,
    parameter int unsigned LoadDepth = RfLoadDepthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_req_waddr_i,
    output logic                 lsu_req_ready_o,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 dummy_instr_wb_i,
    input  logic [4:0]           id_raddr_a_i,
    input  logic [4:0]           id_raddr_b_i,
    output logic                 stall_o,
    output logic                 we_a_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 err_o
);

    rf_wr_t skid_q, skid_d;
    rf_wr_t out_q, out_d;
    logic   err_q, err_d;

    logic                   q_full, q_empty;
    logic [4:0]             q_head;
    logic [LoadDepth*5-1:0] q_entries;
    logic [LoadDepth-1:0]   q_vld;

    logic                   load_ret, ex_acc, lsu_push;
    logic                   sel_any;
    logic [4:0]             sel_addr;
    logic [RfDataWidth-1:0] sel_data;

    assign ex_ready_o      = !skid_q.we;
    assign lsu_req_ready_o = !q_full;
    assign load_ret        = lsu_rvalid_i && !q_empty;
    assign ex_acc          = ex_valid_i && ex_ready_o;
    assign lsu_push        = lsu_req_i && !q_full;

    ibex_rf_load_queue #(
        .Depth (LoadDepth)
    ) u_load_queue (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (lsu_push),
        .push_addr_i   (lsu_req_waddr_i),
        .pop_i         (load_ret),
        .head_o        (q_head),
        .full_o        (q_full),
        .empty_o       (q_empty),
        .entries_o     (q_entries),
        .entry_valid_o (q_vld)
    );

    // Load returns win because the memory side cannot be back-pressured.
    always_comb begin
        sel_any  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        skid_d   = skid_q;
        out_d    = out_q;
        out_d.we = 1'b0;
        if (load_ret) begin
            sel_any  = 1'b1;
            sel_addr = q_head;
            sel_data = RfDataWidth'(lsu_rdata_i);
        end else if (skid_q.we) begin
            sel_any   = 1'b1;
            sel_addr  = skid_q.waddr;
            sel_data  = skid_q.wdata;
            skid_d.we = 1'b0;
        end else if (ex_acc) begin
            sel_any  = 1'b1;
            sel_addr = ex_waddr_i;
            sel_data = RfDataWidth'(ex_wdata_i);
        end
        if (ex_acc && (load_ret || skid_q.we)) begin
            skid_d.we    = 1'b1;
            skid_d.waddr = ex_waddr_i;
            skid_d.wdata = RfDataWidth'(ex_wdata_i);
        end
        if (sel_any) begin
            out_d.we    = (sel_addr != 5'd0) || dummy_instr_wb_i;
            out_d.waddr = sel_addr;
            out_d.wdata = sel_data;
        end
    end

    always_comb begin
        err_d = (lsu_rvalid_i && q_empty) || (lsu_req_i && q_full);
        if (RV32E && ((ex_acc && ex_waddr_i[4]) || (lsu_push && lsu_req_waddr_i[4]))) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        stall_o = rf_addr_hit(id_raddr_a_i, skid_q.waddr, skid_q.we) ||
                  rf_addr_hit(id_raddr_b_i, skid_q.waddr, skid_q.we) ||
                  rf_addr_hit(id_raddr_a_i, out_q.waddr, out_q.we)   ||
                  rf_addr_hit(id_raddr_b_i, out_q.waddr, out_q.we);
        for (int i = 0; i < LoadDepth; i++) begin
            if (rf_addr_hit(id_raddr_a_i, q_entries[i*5 +: 5], q_vld[i]) ||
                rf_addr_hit(id_raddr_b_i, q_entries[i*5 +: 5], q_vld[i])) begin
                stall_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            skid_q <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            skid_q <= skid_d;
            out_q  <= out_d;
            err_q  <= err_d;
        end
    end

    assign we_a_o    = out_q.we;
    assign waddr_a_o = out_q.waddr;
    assign wdata_a_o = out_q.wdata[DataWidth-1:0];
    assign err_o     = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// tb/tb_ibex_rf_write_arbiter.sv - directed self-checking bench for the register file write arbiter
module tb_ibex_rf_write_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        lsu_req_i;
    logic [4:0]  lsu_req_waddr_i;
    logic        lsu_req_ready_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic        dummy_instr_wb_i;
    logic [4:0]  id_raddr_a_i;
    logic [4:0]  id_raddr_b_i;
    logic        stall_o;
    logic        we_a_o;
    logic [4:0]  waddr_a_o;
    logic [31:0] wdata_a_o;
    logic        err_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_write_arbiter #(
        .RV32E     (1'b1),
        .DataWidth (32),
        .LoadDepth (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ex_valid_i       (ex_valid_i),
        .ex_waddr_i       (ex_waddr_i),
        .ex_wdata_i       (ex_wdata_i),
        .ex_ready_o       (ex_ready_o),
        .lsu_req_i        (lsu_req_i),
        .lsu_req_waddr_i  (lsu_req_waddr_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_rvalid_i     (lsu_rvalid_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .dummy_instr_wb_i (dummy_instr_wb_i),
        .id_raddr_a_i     (id_raddr_a_i),
        .id_raddr_b_i     (id_raddr_b_i),
        .stall_o          (stall_o),
        .we_a_o           (we_a_o),
        .waddr_a_o        (waddr_a_o),
        .wdata_a_o        (wdata_a_o),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(we_a_o), 32'(we));
        chk({tag, "_waddr"}, 32'(waddr_a_o), 32'(a));
        chk({tag, "_wdata"}, wdata_a_o, d);
    endtask

    initial begin
        rst_ni = 1'b0;
        ex_valid_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        lsu_req_i = 1'b0; lsu_req_waddr_i = '0;
        lsu_rvalid_i = 1'b0; lsu_rdata_i = '0;
        dummy_instr_wb_i = 1'b0;
        id_raddr_a_i = 5'd5; id_raddr_b_i = 5'd0;
        tick();
        tick();
        rst_ni = 1'b1;
        settle();
        chk_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_req_ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);

        // ALU write x5
        ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234_5678;
        settle();
        chk("alu_ready", 32'(ex_ready_o), 32'd1);
        tick();
        ex_valid_i = 1'b0;
        settle();
        chk_wr("alu", 1'b1, 5'd5, 32'h1234_5678);
        chk("alu_stall", 32'(stall_o), 32'd1);
        tick();
        chk("alu_we_once", 32'(we_a_o), 32'd0);
        chk("alu_stall_clr", 32'(stall_o), 32'd0);

        // Load x7 then collision of ALU x3 with the load return
        lsu_req_i = 1'b1; lsu_req_waddr_i = 5'd7;
        tick();
        lsu_req_i = 1'b0;
        ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hA;
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hBEEF;
        tick();
        ex_valid_i = 1'b0; lsu_rvalid_i = 1'b0;
        settle();
        chk_wr("coll_load", 1'b1, 5'd7, 32'hBEEF);
        chk("coll_ex_ready_lo", 32'(ex_ready_o), 32'd0);
        tick();
        chk_wr("coll_skid", 1'b1, 5'd3, 32'hA);
        chk("coll_ex_ready_hi", 32'(ex_ready_o), 32'd1);
        tick();
        chk("coll_idle", 32'(we_a_o), 32'd0);

        // Fill the queue, overflow push, then drain in order
        id_raddr_a_i = 5'd0; id_raddr_b_i = 5'd2;
        lsu_req_i = 1'b1; lsu_req_waddr_i = 5'd1;
        tick();
        lsu_req_waddr_i = 5'd2;
        tick();
        lsu_req_i = 1'b0;
        settle();
        chk("full_ready", 32'(lsu_req_ready_o), 32'd0);
        chk("full_err0", 32'(err_o), 32'd0);
        chk("full_stall", 32'(stall_o), 32'd1);
        lsu_req_i = 1'b1; lsu_req_waddr_i = 5'd4;
        tick();
        lsu_req_i = 1'b0;
        settle();
        chk("ovf_err", 32'(err_o), 32'd1);
        tick();
        chk("ovf_err_pulse", 32'(err_o), 32'd0);
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h11;
        tick();
        lsu_rdata_i = 32'h22;
        settle();
        chk_wr("ret1", 1'b1, 5'd1, 32'h11);
        chk("ret1_stall", 32'(stall_o), 32'd1);
        tick();
        lsu_rvalid_i = 1'b0;
        settle();
        chk_wr("ret2", 1'b1, 5'd2, 32'h22);
        chk("ret2_stall", 32'(stall_o), 32'd1);
        tick();
        chk("ret_done_we", 32'(we_a_o), 32'd0);
        chk("ret_done_stall", 32'(stall_o), 32'd0);
        chk("ret_done_ready", 32'(lsu_req_ready_o), 32'd1);
        chk("ret_done_err", 32'(err_o), 32'd0);
        id_raddr_b_i = 5'd0;

        // Return with nothing outstanding
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hDEAD;
        tick();
        lsu_rvalid_i = 1'b0;
        settle();
        chk("empty_err", 32'(err_o), 32'd1);
        chk("empty_we", 32'(we_a_o), 32'd0);
        tick();
        chk("empty_err_pulse", 32'(err_o), 32'd0);

        // x0 writes, with and without dummy, then an illegal RV32E address
        ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h55;
        tick();
        settle();
        chk("x0_we", 32'(we_a_o), 32'd0);
        dummy_instr_wb_i = 1'b1;
        tick();
        settle();
        chk_wr("x0_dummy", 1'b1, 5'd0, 32'h55);
        dummy_instr_wb_i = 1'b0;
        ex_waddr_i = 5'd20; ex_wdata_i = 32'h66;
        tick();
        ex_valid_i = 1'b0;
        settle();
        chk("rv32e_err", 32'(err_o), 32'd1);
        tick();
        chk("rv32e_err_pulse", 32'(err_o), 32'd0);

        // Reset with the skid valid and one load pending
        lsu_req_i = 1'b1; lsu_req_waddr_i = 5'd6;
        tick();
        lsu_req_waddr_i = 5'd9;
        tick();
        lsu_req_i = 1'b0;
        ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h77;
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h66;
        tick();
        ex_valid_i = 1'b0; lsu_rvalid_i = 1'b0;
        id_raddr_a_i = 5'd3; id_raddr_b_i = 5'd9;
        settle();
        chk_wr("pre_rst", 1'b1, 5'd6, 32'h66);
        chk("pre_rst_ex_ready", 32'(ex_ready_o), 32'd0);
        chk("pre_rst_stall", 32'(stall_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        settle();
        chk("mid_rst_ex_ready", 32'(ex_ready_o), 32'd1);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_we", 32'(we_a_o), 32'd0);
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h99;
        tick();
        lsu_rvalid_i = 1'b0;
        settle();
        chk("mid_rst_err", 32'(err_o), 32'd1);
        chk("mid_rst_no_we", 32'(we_a_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
